// File: rtl/spi_pkg.sv
// Shared SPI definitions used by spi_slave (and spi_master).
// Holds the frame FSM state encoding, the CPOL/CPHA mode constants and a
// constant log2 function for sizing counters.
package spi_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   localparam bit SPI_CPOL_LOW   = 1'b0;
   localparam bit SPI_CPOL_HIGH  = 1'b1;
   localparam bit SPI_CPHA_LEAD  = 1'b0;
   localparam bit SPI_CPHA_TRAIL = 1'b1;

   // Bits needed to count 0..value-1 (minimum 1).
   function automatic int spi_clog2(input int value);
      int result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Client-side handshake bundle of spi_slave.
//   tx_data/tx_valid/tx_ready : one-entry transmit buffer write port
//   rx_data/rx_valid          : received word and its one-clk strobe
//   busy/frame_err            : frame active, mid-word cs_n deassert pulse
//   tx_underrun               : only with SPI_SLAVE_UNDERRUN_EN defined
// Modport slave is taken by spi_slave, modport master by the client.
interface spi_slave_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;
   logic                  frame_err;
`ifdef SPI_SLAVE_UNDERRUN_EN
   logic                  tx_underrun;
`endif

   modport slave (
      input  tx_data, tx_valid,
`ifdef SPI_SLAVE_UNDERRUN_EN
      output tx_underrun,
`endif
      output tx_ready, rx_data, rx_valid, busy, frame_err
   );

   modport master (
      output tx_data, tx_valid,
`ifdef SPI_SLAVE_UNDERRUN_EN
      input  tx_underrun,
`endif
      input  tx_ready, rx_data, rx_valid, busy, frame_err
   );
endinterface

// File: rtl/spi_sync_edge.sv
// STAGES-flop synchroniser for an asynchronous pin followed by one extra
// flop, producing one-clk rise/fall pulses of the synchronised level.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   rise, fall : one-clk pulses on synchronised transitions
// RST_VAL should equal the pin's idle level so reset release makes no edge.
module spi_sync_edge #(
   parameter int STAGES  = 2,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q;
   logic              last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         last_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~last_q;
   assign fall = ~sync_q[STAGES-1] & last_q;
endmodule

// File: rtl/spi_slave.sv
// SPI responder. Oversamples sclk/cs_n/mosi with clk (clk >= 4x sclk),
// receives MSB-first into rx_data and drives miso MSB-first from a
// one-entry transmit buffer. Back-to-back words under one cs_n low.
//   clk, rst_n      : system clock, async active-low reset
//   sclk, cs_n, mosi: SPI pins from the initiator (asynchronous)
//   miso            : serial data out, 0 while no frame is active
//   bus             : spi_slave_if.slave client handshake
// Parameters: DATA_WIDTH, CPOL, CPHA, SYNC_STAGES (>= 2).
// Build option: SPI_SLAVE_UNDERRUN_EN adds bus.tx_underrun, a one-clk
// pulse whenever a word load finds the transmit buffer empty.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | no frame; waiting for synchronised cs_n falling edge
// ST_ACTIVE | frame in progress; sampling mosi and shifting miso
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter bit CPOL        = SPI_CPOL_LOW,
   parameter bit CPHA        = SPI_CPHA_LEAD,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   spi_slave_if.slave bus
);
   localparam int              CNT_W    = spi_clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic mosi_s;
   logic lead_edge, trail_edge, sample_en, shift_en;

   spi_state_e state_q, state_d;
   logic frame_start, word_done, abort, active, word_load;

   logic [DATA_WIDTH-1:0] tx_buf, tx_shift, rx_shift, rx_data_q;
   logic                  tx_full, tx_accept, rx_valid_q, frame_err_q;
   logic [CNT_W-1:0]      bit_cnt;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .d(cs_n), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi needs no edge detect; its last stage lines up with the sclk edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_q <= '0;
      else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_q[SYNC_STAGES-1];

   assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge = CPOL ? sclk_rise : sclk_fall;
   assign sample_en  = CPHA ? trail_edge : lead_edge;
   assign shift_en   = CPHA ? lead_edge  : trail_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
         ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // A sample coinciding with cs_n rising is still taken; only a word left
   // partial after that sample counts as a framing error.
   always_comb begin
      active      = 1'b0;
      frame_start = 1'b0;
      word_done   = 1'b0;
      abort       = 1'b0;
      case (state_q)
         ST_IDLE: frame_start = cs_fall;
         ST_ACTIVE: begin
            active    = 1'b1;
            word_done = sample_en && (bit_cnt == LAST_BIT);
            abort     = cs_rise && !word_done && (sample_en || (bit_cnt != '0));
         end
         default: ;
      endcase
   end

   assign word_load = frame_start || (word_done && !cs_rise);
   assign tx_accept = bus.tx_valid && !tx_full;

   // A load in the same clk as an accept sees the old empty buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_buf  <= '0;
         tx_full <= 1'b0;
      end else begin
         if (tx_accept) tx_buf <= bus.tx_data;
         tx_full <= tx_accept || (tx_full && !word_load);
      end
   end

   // No shift while bit_cnt is 0: that shift edge belongs to a freshly
   // loaded word whose MSB must stay on miso until the initiator samples it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= '0;
      end else if (word_load) begin
         tx_shift <= tx_full ? tx_buf : '0;
      end else if (active && shift_en && (bit_cnt != '0)) begin
         tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift    <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         bit_cnt     <= '0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= abort;
         if (active && sample_en) rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
         if (frame_start) begin
            bit_cnt <= '0;
         end else if (word_done) begin
            bit_cnt    <= '0;
            rx_data_q  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            rx_valid_q <= 1'b1;
         end else if (active && sample_en) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

`ifdef SPI_SLAVE_UNDERRUN_EN
   logic underrun_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) underrun_q <= 1'b0;
      else        underrun_q <= word_load && !tx_full;
   end
   assign bus.tx_underrun = underrun_q;
`endif

   assign miso          = active ? tx_shift[DATA_WIDTH-1] : 1'b0;
   assign bus.busy      = active;
   assign bus.tx_ready  = !tx_full;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: four instances (SPI modes 0..3) driven in lockstep
// by one behavioural SPI initiator. Expected words come from a word-level
// model: the slave receives the words sent; the initiator receives the
// queued transmit words in order, zeros once the queue is exhausted.
module tb_spi_slave;
   localparam int H = 5;   // sclk half period in clk cycles

   logic clk, rst_n, cs_n, phase, mosi_h0, mosi_h1;
   logic [3:0] sclk_v, mosi_v, miso_v, tx_ready_v, rx_valid_v, busy_v, frame_err_v;
   logic [7:0] rx_data_v [4];
`ifdef SPI_SLAVE_UNDERRUN_EN
   logic [3:0] und_v;
   int und_cnt [4];
`endif

   logic [7:0] tx_list [$];
   logic [7:0] fw [$];
   logic [7:0] mrx [4];
   logic [7:0] mrx_w [4][8];
   logic [7:0] rx_cap [4][16];
   int rxv_cnt [4];
   int ferr_cnt [4];
   logic [7:0] exp_rx;
   int n_assert, n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_if #(.DATA_WIDTH(8)) bus ();
      logic       tx_valid_l;
      logic [7:0] tx_data_l;
      int         tx_idx;

      assign sclk_v[g]      = phase ^ (g >= 2);
      assign mosi_v[g]      = (g % 2 == 1) ? mosi_h1 : mosi_h0;
      assign bus.tx_data    = tx_data_l;
      assign bus.tx_valid   = tx_valid_l;
      assign tx_ready_v[g]  = bus.tx_ready;
      assign rx_data_v[g]   = bus.rx_data;
      assign rx_valid_v[g]  = bus.rx_valid;
      assign busy_v[g]      = bus.busy;
      assign frame_err_v[g] = bus.frame_err;
`ifdef SPI_SLAVE_UNDERRUN_EN
      assign und_v[g]       = bus.tx_underrun;
`endif

      spi_slave #(.DATA_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1), .SYNC_STAGES(2)) u_dut (
         .clk(clk), .rst_n(rst_n), .sclk(sclk_v[g]), .cs_n(cs_n),
         .mosi(mosi_v[g]), .miso(miso_v[g]), .bus(bus)
      );

      // Client: feeds tx_list into the buffer whenever it reports ready.
      initial begin
         tx_valid_l = 1'b0;
         tx_data_l  = '0;
         tx_idx     = 0;
         forever begin
            @(negedge clk);
            if (tx_valid_l) begin
               tx_valid_l = 1'b0;
               tx_idx++;
            end else if (rst_n && bus.tx_ready && tx_idx < tx_list.size()) begin
               tx_data_l  = tx_list[tx_idx];
               tx_valid_l = 1'b1;
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         rxv_cnt[i] = 0;
         ferr_cnt[i] = 0;
`ifdef SPI_SLAVE_UNDERRUN_EN
         und_cnt[i] = 0;
`endif
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (rx_valid_v[i]) begin
               rx_cap[i][rxv_cnt[i] % 16] = rx_data_v[i];
               rxv_cnt[i]++;
            end
            if (frame_err_v[i]) ferr_cnt[i]++;
`ifdef SPI_SLAVE_UNDERRUN_EN
            if (und_v[i]) und_cnt[i]++;
`endif
         end
      end
   end

   task automatic check(input string tag, input int mode, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s mode%0d: observed 0x%0h expected 0x%0h", tag, mode, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_miso"},      i, 32'(miso_v[i]),      0);
         check({tag, "_tx_ready"},  i, 32'(tx_ready_v[i]),  1);
         check({tag, "_rx_data"},   i, 32'(rx_data_v[i]),   0);
         check({tag, "_rx_valid"},  i, 32'(rx_valid_v[i]),  0);
         check({tag, "_busy"},      i, 32'(busy_v[i]),      0);
         check({tag, "_frame_err"}, i, 32'(frame_err_v[i]), 0);
      end
   endtask

   // Behavioural initiator for all four modes at once: CPHA=0 data changes
   // on the trailing edge and is captured on the leading; CPHA=1 the reverse.
   task automatic run_frame(input int nbits);
      mosi_h0 = fw[0][7];
      cs_n = 1'b0;
      repeat (H) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
         mosi_h1 = fw[b / 8][7 - (b % 8)];
         for (int i = 0; i < 4; i++) if (i % 2 == 0) mrx[i] = {mrx[i][6:0], miso_v[i]};
         phase = 1'b1;
         repeat (H) @(negedge clk);
         for (int i = 0; i < 4; i++) if (i % 2 == 1) mrx[i] = {mrx[i][6:0], miso_v[i]};
         phase = 1'b0;
         if (b + 1 < nbits) mosi_h0 = fw[(b + 1) / 8][7 - ((b + 1) % 8)];
         if (b % 8 == 7) for (int i = 0; i < 4; i++) mrx_w[i][b / 8] = mrx[i];
         repeat (H) @(negedge clk);
      end
      cs_n = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   // n_tx words were appended to tx_list for this frame; fw holds mosi words.
   task automatic do_frame(input int nbits, input int n_tx);
      int complete, base;
      int rx0 [4];
      int fe0 [4];
`ifdef SPI_SLAVE_UNDERRUN_EN
      int un0 [4];
`endif
      complete = nbits / 8;
      base = tx_list.size() - n_tx;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx0[i] = rxv_cnt[i];
         fe0[i] = ferr_cnt[i];
`ifdef SPI_SLAVE_UNDERRUN_EN
         un0[i] = und_cnt[i];
`endif
      end
      run_frame(nbits);
      if (complete > 0) exp_rx = fw[complete - 1];
      for (int i = 0; i < 4; i++) begin
         check("rx_valid_count", i, rxv_cnt[i] - rx0[i], complete);
         for (int k = 0; k < complete; k++) begin
            check("rx_word", i, 32'(rx_cap[i][(rx0[i] + k) % 16]), 32'(fw[k]));
            check("master_rx", i, 32'(mrx_w[i][k]), (k < n_tx) ? 32'(tx_list[base + k]) : 0);
         end
         check("rx_data_hold", i, 32'(rx_data_v[i]), 32'(exp_rx));
         check("frame_err_count", i, ferr_cnt[i] - fe0[i], (nbits % 8 != 0) ? 1 : 0);
         check("busy_after", i, 32'(busy_v[i]), 0);
         check("tx_ready_after", i, 32'(tx_ready_v[i]), 1);
`ifdef SPI_SLAVE_UNDERRUN_EN
         check("underrun_count", i, und_cnt[i] - un0[i], complete + 1 - n_tx);
`endif
      end
   endtask

   initial begin
      int rx_before [4];
      int nw, ntx;
      n_assert = 0;
      n_fail   = 0;
      exp_rx   = 8'h00;
      rst_n = 1'b0; cs_n = 1'b1; phase = 1'b0; mosi_h0 = 1'b0; mosi_h1 = 1'b0;
      for (int i = 0; i < 4; i++) mrx[i] = '0;
      repeat (4) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_values("post_reset");

      // single word, buffer preloaded
      fw = {8'hA5};
      tx_list.push_back(8'h3C);
      do_frame(8, 1);

      // two words under one cs_n, buffer refilled in between
      fw = {8'h11, 8'h22};
      tx_list.push_back(8'h55);
      tx_list.push_back(8'hAA);
      do_frame(16, 2);

      // underrun: nothing queued
      fw = {8'h69};
      do_frame(8, 0);

      // abort after 5 bits, then a clean frame
      fw = {8'h99};
      do_frame(5, 0);
      fw = {8'h7E};
      tx_list.push_back(8'h81);
      do_frame(8, 1);

      // asynchronous reset mid-word
      for (int i = 0; i < 4; i++) rx_before[i] = rxv_cnt[i];
      mosi_h0 = 1'b1; mosi_h1 = 1'b1;
      cs_n = 1'b0;
      repeat (H) @(negedge clk);
      repeat (3) begin
         phase = 1'b1; repeat (H) @(negedge clk);
         phase = 1'b0; repeat (H) @(negedge clk);
      end
      phase = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) check("busy_mid_frame", i, 32'(busy_v[i]), 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      @(negedge clk);
      cs_n = 1'b1; phase = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) check("no_rx_after_reset", i, rxv_cnt[i] - rx_before[i], 0);
      exp_rx = 8'h00;
      fw = {8'hC3};
      tx_list.push_back(8'h5A);
      do_frame(8, 1);

      // randomized frames
      for (int r = 0; r < 4; r++) begin
         nw  = $urandom_range(1, 3);
         ntx = $urandom_range(0, nw);
         fw.delete();
         for (int k = 0; k < nw; k++) fw.push_back(8'($urandom));
         for (int k = 0; k < ntx; k++) tx_list.push_back(8'($urandom));
         do_frame(8 * nw, ntx);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
